mic_capture: RTL and testbench
==============================

# mic_capture

Triggered capture writer for the signal-delay datapath: accepts microphone samples over a valid/ready handshake and produces the write side (wr, wr_addr, din) of the two-port sample RAM that the delay/playback reader consumes. While armed it writes a circular pre-trigger history. On a rising threshold crossing it latches the trigger address, writes a programmable number of post-trigger samples, and then stops, leaving a stable snapshot for the reader.

## Interface
- WIDTH, 9: sample width; must equal the RAM data width.
- ADDR_WIDTH, 9: RAM address width; buffer depth is 2^ADDR_WIDTH.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- arm  in  1  single-cycle start request.
- abort  in  1  single-cycle stop request.
- threshold  in  WIDTH  unsigned trigger level.
- post_len  in  ADDR_WIDTH  number of samples to write after the trigger sample.
- mic_valid  in  1  input sample valid.
- mic_signal  in  WIDTH  input sample.
- mic_ready  out  1  block can accept a sample.
- wr  out  1  RAM write enable (registered).
- wr_addr  out  ADDR_WIDTH  RAM write address (registered).
- wr_data  out  WIDTH  RAM write data (registered).
- trig_addr  out  ADDR_WIDTH  address holding the trigger sample.
- pre_full  out  1  at least 2^ADDR_WIDTH samples written since arm.
- busy  out  1  high in ARMED or POST.
- done  out  1  capture complete.

## Operation
- States: IDLE, ARMED, POST, DONE. Reset leaves the block in IDLE.
- accept = mic_valid & mic_ready.
- mic_ready = 1 in ARMED and POST; 0 in IDLE and DONE. mic_ready is combinational from state only and never depends on mic_valid.
- Internal write pointer ptr (ADDR_WIDTH bits):
  - arm clears ptr to 0.
  - Each accept writes to ptr, then ptr increments modulo 2^ADDR_WIDTH (wraps from 2^ADDR_WIDTH-1 to 0).
- IDLE, on arm: go to ARMED. Clear ptr, pre_full, trig_addr and the prev-valid flag.
- ARMED, on each accept:
  - Write the sample.
  - Trigger when prev-valid=1, prev < threshold and mic_signal >= threshold (unsigned compare).
  - The first sample after arm never triggers. It only loads prev and sets prev-valid.
  - On trigger:
    - trig_addr <= ptr.
    - Load the post counter with post_len.
    - Go to POST, or go directly to DONE if post_len == 0.
  - If a write wraps ptr to 0, set pre_full.
- POST, on each accept:
  - Write the sample and decrement the post counter.
  - When the counter goes 1 -> 0, go to DONE.
  - pre_full keeps updating on wrap.
- DONE: no writes. done=1. Holds until arm or abort.
  - arm restarts exactly as from IDLE.
  - abort goes to IDLE.
- abort in any state returns to IDLE on the next edge. The sample accepted in that same cycle is still written. trig_addr and pre_full hold their values.
- arm and abort in the same cycle: abort wins.
- arm while in ARMED or POST: ignored.
- busy = state in {ARMED, POST}. done = state is DONE.

## Timing
- Reset values: wr=0, wr_addr=0, wr_data=0, trig_addr=0, pre_full=0, busy=0, done=0, mic_ready=0.
- Write latency is 1 cycle. The accept at edge N drives wr=1 with wr_addr = the ptr value at accept and wr_data = mic_signal during cycle N+1.
- When there is no accept, wr=0 on the next cycle. wr_addr and wr_data hold their previous values.
- Throughput: one sample per cycle sustained.
- State, trig_addr and pre_full update on the same edge that registers the corresponding write.
- done therefore rises in the same cycle that wr presents the final sample.
- Total samples written from trigger to DONE = post_len + 1, including the trigger sample.
- Asynchronous reset mid-capture clears all outputs immediately. Any in-flight write is dropped: wr goes to 0 without waiting for clk.

## Test plan
- Use ADDR_WIDTH=4 and threshold=100 unless stated otherwise.
- Reset and idle: hold rst=0, then release. Drive mic_valid=1 with no arm -> mic_ready=0, wr stays 0, all outputs 0.
- Basic capture:
  - Stimulus: arm, then samples 10, 50, 120, 130, 140 with post_len=2.
  - Trigger on 120 at address 2 -> trig_addr=2.
  - Writes go to addresses 0..4.
  - done=1 in the same cycle as the write of 140 to address 4.
  - mic_ready=0 afterwards.
- No trigger on the first sample: arm, then samples 150, 160 -> no trigger (prev-valid=0, then prev is not below threshold). State stays ARMED.
- Wrap and pre_full:
  - Stimulus: arm, then 20 samples below threshold.
  - Addresses go 0..15 then 0..3.
  - pre_full rises with the write to address 15.
  - busy=1 throughout.
- Zero post length: post_len=0, arm, then 10, 200 -> trig_addr=1, done=1 with that write, no further writes.
- Control conflicts:
  - abort in POST, accepting in the same cycle -> that sample is written, then IDLE. trig_addr is held.
  - arm+abort together in DONE -> IDLE.
  - Asynchronous reset during POST -> wr, busy, done drop to 0 immediately.

Source files
------------

// File: rtl/mic_capture_if.sv
// ----------------------------------------------------------------------------
// mic_capture_if
// Sample-stream handshake plus the RAM write port of the capture writer.
//   mic_valid / mic_signal / mic_ready : incoming microphone samples
//   wr / wr_addr / wr_data             : registered write side of the sample RAM
// slave  : the capture block (consumes samples, drives the RAM write port)
// master : the sample source, which also observes the RAM write port
// ----------------------------------------------------------------------------
interface mic_capture_if #(
    parameter int WIDTH      = 9,
    parameter int ADDR_WIDTH = 9
);
    logic                  mic_valid;
    logic [WIDTH-1:0]      mic_signal;
    logic                  mic_ready;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0]      wr_data;

    modport master (
        output mic_valid, mic_signal,
        input  mic_ready, wr, wr_addr, wr_data
    );

    modport slave (
        input  mic_valid, mic_signal,
        output mic_ready, wr, wr_addr, wr_data
    );
endinterface

// File: rtl/mic_capture.sv
// ----------------------------------------------------------------------------
// mic_capture
// Triggered capture writer. While armed it writes a circular pre-trigger
// history into the sample RAM; on a rising threshold crossing it latches the
// trigger address, writes post_len further samples and stops.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   arm, abort      single-cycle start / stop requests (abort wins)
//   threshold       unsigned trigger level
//   post_len        samples written after the trigger sample
//   bus             sample handshake in, RAM write port out (slave modport)
//   trig_addr       RAM address holding the trigger sample
//   pre_full        a full buffer's worth of samples written since arm
//   busy, done      ARMED/POST, and capture complete
// ----------------------------------------------------------------------------
module mic_capture #(
    parameter int WIDTH      = 9,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [WIDTH-1:0]      threshold,
    input  logic [ADDR_WIDTH-1:0] post_len,
    mic_capture_if.slave          bus,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  pre_full,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q, cnt_q, wr_addr_q, trig_addr_q;
    logic [WIDTH-1:0]      prev_q, wr_data_q;
    logic                  prev_vld_q, wr_q, pre_full_q;

    logic                  accept, start, wrap, hit;
    logic [ADDR_WIDTH-1:0] ptr_d;

    assign bus.mic_ready = (state_q == S_ARMED) || (state_q == S_POST);
    assign accept        = bus.mic_valid && bus.mic_ready;
    // arm is honoured only when no capture is running; abort overrides it
    assign start         = arm && !abort && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign ptr_d         = ptr_q + ADDR_WIDTH'(1);
    assign wrap          = (ptr_q == {ADDR_WIDTH{1'b1}});
    // rising crossing needs a previous sample; the first one after arm only primes prev
    assign hit           = prev_vld_q && (prev_q < threshold) && (bus.mic_signal >= threshold);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            wr_q        <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            trig_addr_q <= '0;
            pre_full_q  <= 1'b0;
        end else begin
            // write path: any accepted sample is written, even on an abort cycle
            wr_q <= accept;
            if (accept) begin
                wr_addr_q <= ptr_q;
                wr_data_q <= bus.mic_signal;
                ptr_q     <= ptr_d;
            end

            if (start) begin
                state_q     <= S_ARMED;
                ptr_q       <= '0;
                pre_full_q  <= 1'b0;
                trig_addr_q <= '0;
                prev_vld_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: ;
                    S_ARMED: begin
                        if (abort) begin
                            state_q <= S_IDLE;
                        end else if (accept) begin
                            prev_q     <= bus.mic_signal;
                            prev_vld_q <= 1'b1;
                            if (wrap) pre_full_q <= 1'b1;
                            if (hit) begin
                                trig_addr_q <= ptr_q;
                                cnt_q       <= post_len;
                                state_q     <= (post_len == '0) ? S_DONE : S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        if (abort) begin
                            state_q <= S_IDLE;
                        end else if (accept) begin
                            cnt_q <= cnt_q - ADDR_WIDTH'(1);
                            if (wrap) pre_full_q <= 1'b1;
                            if (cnt_q == ADDR_WIDTH'(1)) state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (abort) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.wr      = wr_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign trig_addr   = trig_addr_q;
    assign pre_full    = pre_full_q;
    assign busy        = (state_q == S_ARMED) || (state_q == S_POST);
    assign done        = (state_q == S_DONE);
endmodule

// File: tb/tb_mic_capture.sv
module tb_mic_capture;
    localparam int W     = 9;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  threshold = W'(100);
    logic [AW-1:0] post_len = '0;
    logic [AW-1:0] trig_addr;
    logic          pre_full, busy, done;

    mic_capture_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

    mic_capture #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort),
        .threshold(threshold), .post_len(post_len), .bus(bus),
        .trig_addr(trig_addr), .pre_full(pre_full), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {int addr; int data; bit pf; bit dn;} wr_t;
    wr_t wq[$];          // observed RAM writes
    int  smp[$];         // stimulus samples of the current capture
    int  e_addr[$], e_data[$];
    int  e_n, e_trig;
    bit  e_done;

    // RAM write observer, sampled away from the active edge
    always @(negedge clk)
        if (bus.wr === 1'b1)
            wq.push_back('{int'(bus.wr_addr), int'(bus.wr_data), pre_full, done});

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic start(input int pl, input int th);
        bus.mic_valid = 1'b0;
        abort = 1'b1; step(); abort = 1'b0;
        post_len = AW'(pl); threshold = W'(th);
        arm = 1'b1; step(); arm = 1'b0;
        wq.delete();
    endtask

    // feed smp[], optionally with random idle gaps; stop once the block stops accepting
    task automatic drive(input bit gaps);
        for (int i = 0; i < smp.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                bus.mic_valid = 1'b0; bus.mic_signal = W'($urandom); step();
            end
            if (bus.mic_ready !== 1'b1) break;
            bus.mic_valid = 1'b1; bus.mic_signal = W'(smp[i]); step();
        end
        bus.mic_valid = 1'b0;
        step(); step();
    endtask

    // reference: first rising crossing after the first sample triggers; trigger
    // plus pl more samples are written, addresses count up modulo the depth
    task automatic model(input int pl, input int th);
        int k = -1;
        e_addr.delete(); e_data.delete();
        for (int i = 1; i < smp.size(); i++)
            if (k < 0 && smp[i-1] < th && smp[i] >= th) k = i;
        e_n = smp.size(); e_done = 1'b0; e_trig = 0;
        if (k >= 0) begin
            e_trig = k % DEPTH;
            if (k + pl + 1 <= smp.size()) begin e_n = k + pl + 1; e_done = 1'b1; end
        end
        for (int i = 0; i < e_n; i++) begin
            e_addr.push_back(i % DEPTH); e_data.push_back(smp[i]);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({bus.wr, bus.wr_addr, bus.wr_data, trig_addr, pre_full, busy, done, bus.mic_ready} !== '0) begin
            bad++; $display("FAIL reset_outputs got wr=%0b a=%0d d=%0d t=%0d pf=%0b b=%0b dn=%0b rdy=%0b exp all 0",
                bus.wr, bus.wr_addr, bus.wr_data, trig_addr, pre_full, busy, done, bus.mic_ready);
        end
        rst = 1'b1;
        step();
        wq.delete();
        bus.mic_valid = 1'b1; bus.mic_signal = W'(200);
        repeat (5) step();
        total++;
        if (wq.size() !== 0 || bus.mic_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL idle_no_arm got writes=%0d rdy=%0b busy=%0b done=%0b exp 0 0 0 0",
                wq.size(), bus.mic_ready, busy, done);
        end
        bus.mic_valid = 1'b0;
    endtask

    task automatic test_basic();
        smp = '{10, 50, 120, 130, 140};
        start(2, 100); drive(1'b1); model(2, 100);
        total++;
        if (wq.size() !== e_n || e_n !== 5) begin
            bad++; $display("FAIL basic_count got=%0d exp=5", wq.size());
        end
        for (int i = 0; i < e_n && i < wq.size(); i++) begin
            total++;
            if (wq[i].addr !== e_addr[i] || wq[i].data !== e_data[i] || wq[i].dn !== (e_done && i == e_n-1)) begin
                bad++; $display("FAIL basic_wr%0d got a=%0d d=%0d dn=%0b exp a=%0d d=%0d dn=%0b",
                    i, wq[i].addr, wq[i].data, wq[i].dn, e_addr[i], e_data[i], e_done && i == e_n-1);
            end
        end
        total++;
        if (trig_addr !== AW'(2) || done !== 1'b1 || busy !== 1'b0 || bus.mic_ready !== 1'b0) begin
            bad++; $display("FAIL basic_final got t=%0d dn=%0b b=%0b rdy=%0b exp t=2 dn=1 b=0 rdy=0",
                trig_addr, done, busy, bus.mic_ready);
        end
    endtask

    task automatic test_first_no_trig();
        smp = '{150, 160};
        start(3, 100); drive(1'b0);
        total++;
        if (wq.size() !== 2 || busy !== 1'b1 || done !== 1'b0 || trig_addr !== '0 || bus.mic_ready !== 1'b1) begin
            bad++; $display("FAIL first_no_trig got writes=%0d b=%0b dn=%0b t=%0d rdy=%0b exp 2 1 0 0 1",
                wq.size(), busy, done, trig_addr, bus.mic_ready);
        end
    endtask

    task automatic test_wrap();
        smp.delete();
        for (int i = 0; i < 20; i++) smp.push_back($urandom_range(0, 99));
        start($urandom_range(0, 15), 100); drive(1'b1); model(int'(post_len), 100);
        total++;
        if (wq.size() !== 20) begin
            bad++; $display("FAIL wrap_count got=%0d exp=20", wq.size());
        end
        for (int i = 0; i < e_n && i < wq.size(); i++) begin
            total++;
            if (wq[i].addr !== e_addr[i] || wq[i].data !== e_data[i] || wq[i].pf !== (i >= DEPTH-1)) begin
                bad++; $display("FAIL wrap_wr%0d got a=%0d d=%0d pf=%0b exp a=%0d d=%0d pf=%0b",
                    i, wq[i].addr, wq[i].data, wq[i].pf, e_addr[i], e_data[i], i >= DEPTH-1);
            end
        end
        total++;
        if (busy !== 1'b1 || pre_full !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL wrap_final got b=%0b pf=%0b dn=%0b exp 1 1 0", busy, pre_full, done);
        end
    endtask

    task automatic test_zero_post();
        smp = '{10, 200, 30, 40};
        start(0, 100); drive(1'b0);
        total++;
        if (wq.size() !== 2) begin
            bad++; $display("FAIL zero_post_count got=%0d exp=2", wq.size());
        end else if (wq[1].addr !== 1 || wq[1].data !== 200 || wq[1].dn !== 1'b1) begin
            total++; bad++;
            $display("FAIL zero_post_wr got a=%0d d=%0d dn=%0b exp a=1 d=200 dn=1", wq[1].addr, wq[1].data, wq[1].dn);
        end
        total++;
        if (trig_addr !== AW'(1) || done !== 1'b1) begin
            bad++; $display("FAIL zero_post_final got t=%0d dn=%0b exp t=1 dn=1", trig_addr, done);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int th = $urandom_range(50, 150);
            int pl = $urandom_range(0, 15);
            int len = $urandom_range(3, 40);
            smp.delete();
            for (int i = 0; i < len; i++) smp.push_back($urandom_range(0, 255));
            start(pl, th); drive(1'b1); model(pl, th);
            total++;
            if (wq.size() !== e_n) begin
                bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, wq.size(), e_n);
            end
            for (int i = 0; i < e_n && i < wq.size(); i++) begin
                total++;
                if (wq[i].addr !== e_addr[i] || wq[i].data !== e_data[i] ||
                    wq[i].pf !== (i >= DEPTH-1) || wq[i].dn !== (e_done && i == e_n-1)) begin
                    bad++; $display("FAIL rand%0d_wr%0d got a=%0d d=%0d pf=%0b dn=%0b exp a=%0d d=%0d pf=%0b dn=%0b",
                        it, i, wq[i].addr, wq[i].data, wq[i].pf, wq[i].dn,
                        e_addr[i], e_data[i], i >= DEPTH-1, e_done && i == e_n-1);
                end
            end
            total++;
            if (trig_addr !== AW'(e_trig) || done !== e_done || busy !== !e_done) begin
                bad++; $display("FAIL rand%0d_final got t=%0d dn=%0b b=%0b exp t=%0d dn=%0b b=%0b",
                    it, trig_addr, done, busy, e_trig, e_done, !e_done);
            end
        end
    endtask

    task automatic test_abort_post();
        start(5, 100);
        bus.mic_valid = 1'b1; bus.mic_signal = W'(10);  step();
        bus.mic_signal = W'(120); step();
        bus.mic_signal = W'(130); abort = 1'b1; step();
        abort = 1'b0;
        repeat (3) step();   // valid still high: nothing may be accepted in IDLE
        bus.mic_valid = 1'b0; step();
        total++;
        if (wq.size() !== 3) begin
            bad++; $display("FAIL abort_post_count got=%0d exp=3", wq.size());
        end else if (wq[2].addr !== 2 || wq[2].data !== 130) begin
            total++; bad++;
            $display("FAIL abort_post_wr got a=%0d d=%0d exp a=2 d=130", wq[2].addr, wq[2].data);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.mic_ready !== 1'b0 || trig_addr !== AW'(1)) begin
            bad++; $display("FAIL abort_post_state got b=%0b dn=%0b rdy=%0b t=%0d exp 0 0 0 1",
                busy, done, bus.mic_ready, trig_addr);
        end
    endtask

    task automatic test_done_controls();
        smp = '{10, 200};
        start(0, 100); drive(1'b0);
        arm = 1'b1; abort = 1'b1; step();
        arm = 1'b0; abort = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.mic_ready !== 1'b0) begin
            bad++; $display("FAIL arm_abort_done got b=%0b dn=%0b rdy=%0b exp 0 0 0", busy, done, bus.mic_ready);
        end
        smp = '{10, 200};
        start(0, 100); drive(1'b0);
        arm = 1'b1; step(); arm = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || trig_addr !== '0 || pre_full !== 1'b0) begin
            bad++; $display("FAIL rearm_done got b=%0b dn=%0b t=%0d pf=%0b exp 1 0 0 0", busy, done, trig_addr, pre_full);
        end
    endtask

    task automatic test_async_reset();
        start(8, 100);
        bus.mic_valid = 1'b1; bus.mic_signal = W'(10);  step();
        bus.mic_signal = W'(120); step();
        bus.mic_signal = W'(130); step();
        bus.mic_valid = 1'b0;
        total++;
        if (bus.wr !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL async_pre got wr=%0b b=%0b exp 1 1", bus.wr, busy);
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if (bus.wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || trig_addr !== '0 || bus.mic_ready !== 1'b0) begin
            bad++; $display("FAIL async_reset got wr=%0b b=%0b dn=%0b t=%0d rdy=%0b exp all 0",
                bus.wr, busy, done, trig_addr, bus.mic_ready);
        end
        step(); rst = 1'b1; step();
    endtask

    initial begin
        bus.mic_valid  = 1'b0;
        bus.mic_signal = '0;
        test_reset();
        test_basic();
        test_first_no_trig();
        test_wrap();
        test_zero_post();
        test_random();
        test_abort_post();
        test_done_controls();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
